// File: rtl/seg_scan_display.sv
// Byte-to-decimal display stage: sequential double-dabble converter feeding a 4-digit
// common-anode seven-segment scanner. Optional build macro: SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_display #(
  parameter int CLK_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic [1:0] sel,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       bin_q, bin_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       cap_q, cap_d;
  logic [7:0]       shown_q, shown_d;
  logic [3:0]       d0_q, d0_d;
  logic [3:0]       d1_q, d1_d;
  logic [3:0]       d2_q, d2_d;
  logic [CNT_W-1:0] scan_q, scan_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;

  logic [11:0]      bcd_adj;
  logic [19:0]      shifted;
  logic [3:0]       cur_digit;
  logic             blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] code;
    case (d)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = 8'hFF;
    endcase
    return code;
  endfunction

  // Double-dabble step: correct each BCD nibble, then shift the whole {bcd,bin} window.
  always_comb begin
    bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    shifted = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    shown_d = shown_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    case (state_q)
      IDLE: begin
        if (value != shown_q) begin
          bin_d   = value;
          cap_d   = value;
          bcd_d   = 12'd0;
          cnt_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = shifted[19:8];
        bin_d = shifted[7:0];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
        end
      end
      DONE: begin
        d0_d    = bcd_q[3:0];
        d1_d    = bcd_q[7:4];
        d2_d    = bcd_q[11:8];
        shown_d = cap_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scan_d = scan_q + CNT_W'(1);
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end

    case (idx_q)
      2'd0:    cur_digit = d0_q;
      2'd1:    cur_digit = d1_q;
      2'd2:    cur_digit = d2_q;
      default: cur_digit = {2'b00, sel};
    endcase

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Only the tens and hundreds positions are suppressed; ones and select always show.
    blank = ((idx_q == 2'd2) && (d2_q == 4'd0)) ||
            ((idx_q == 2'd1) && (d2_q == 4'd0) && (d1_q == 4'd0));
`else
    blank = 1'b0;
`endif

    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? 8'hFF : seg_code(cur_digit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= 8'd0;
      bcd_q   <= 12'd0;
      cnt_q   <= 3'd0;
      cap_q   <= 8'd0;
      shown_q <= 8'd0;
      d0_q    <= 4'd0;
      d1_q    <= 4'd0;
      d2_q    <= 4'd0;
      scan_q  <= '0;
      idx_q   <= 2'd0;
      an_q    <= 4'b1111;
      seg_q   <= 8'hFF;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      shown_q <= shown_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: stimulus queues the values expected to be
// converted, a monitor pops one per finished conversion and checks the scanned display.
module tb_seg_scan_display;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] value;
  logic [1:0] sel;
  logic [3:0] an;
  logic [7:0] seg;
  logic       busy;

  seg_scan_display #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .sel   (sel),
    .an    (an),
    .seg   (seg),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sb_q[$];
  int edge_cnt;
  int last_target = 0;
  int disp_val = 0;
  int busy_run = 0;
  logic busy_prev = 1'b0;
  logic [1:0] sel_seen;

  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  always @(posedge clk) sel_seen <= sel;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] seg_code(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Reference display: decimal digits of the last completed value, select on slot 3.
  function automatic logic [7:0] exp_seg(input int slot, input int v, input int s);
    int hund, tens, ones;
    hund = v / 100;
    tens = (v / 10) % 10;
    ones = v % 10;
    case (slot)
      0: return seg_code(ones);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      1: return (hund == 0 && tens == 0) ? 8'hFF : seg_code(tens);
      2: return (hund == 0) ? 8'hFF : seg_code(hund);
`else
      1: return seg_code(tens);
      2: return seg_code(hund);
`endif
      default: return seg_code(s);
    endcase
  endfunction

  // Monitor: checks the scan every cycle, and on each busy fall retires one queued value.
  always @(negedge clk) begin
    int slot;
    logic [3:0] an_exp;
    if (reset) begin
      checkOutput("an_in_reset", an, 4'hF);
      checkOutput("seg_in_reset", seg, 8'hFF);
      checkOutput("busy_in_reset", busy, 0);
      sb_q.delete();
      disp_val  = 0;
      busy_run  = 0;
      busy_prev = 1'b0;
    end else begin
      if (edge_cnt == 0) begin
        checkOutput("an_after_release", an, 4'hF);
        checkOutput("seg_after_release", seg, 8'hFF);
      end else begin
        slot   = ((edge_cnt - 1) / CLK_DIV) % 4;
        an_exp = ~(4'b0001 << slot);
        checkOutput("an_scan", an, an_exp);
        checkOutput($sformatf("seg_slot%0d", slot), seg, exp_seg(slot, disp_val, sel_seen));
      end
      if (busy) begin
        busy_run++;
      end else if (busy_prev) begin
        checkOutput("busy_len", busy_run, 9);
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_conversion: got a conversion, expected none queued");
        end else begin
          disp_val = sb_q.pop_front();
        end
        busy_run = 0;
      end
      busy_prev = busy;
    end
  end

  task automatic applyStimulus(input int v, input int s);
    @(posedge clk);
    #1;
    value = 8'(v);
    sel   = 2'(s);
    if (v != last_target) begin
      sb_q.push_back(v);
      last_target = v;
    end
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("idle_timeout", int'(n < budget), 1);
  endtask

  task automatic releaseReset();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_target = 0;
    if (value != 8'd0) begin
      sb_q.push_back(int'(value));
      last_target = int'(value);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    value = 8'd0;
    sel   = 2'd0;
    releaseReset();

    $display("[TB] idle after reset with value 0");
    repeat (24) begin
      @(posedge clk);
      #1;
      checkOutput("busy_idle_zero", busy, 0);
    end

    $display("[TB] value 0 -> 255");
    applyStimulus(255, 0);
    waitIdle(100);
    repeat (16) @(posedge clk);

    $display("[TB] value 128 changed to 9 mid-shift");
    applyStimulus(128, 0);
    repeat (3) @(posedge clk);
    applyStimulus(9, 0);
    waitIdle(100);
    repeat (16) @(posedge clk);

    $display("[TB] sel 3, value 7, then same value again");
    applyStimulus(7, 3);
    waitIdle(100);
    repeat (20) @(posedge clk);
    applyStimulus(7, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("busy_same_value", busy, 0);
    end
    repeat (16) @(posedge clk);

    $display("[TB] random idle changes");
    for (int i = 0; i < 12; i++) begin
      applyStimulus($urandom_range(0, 255), $urandom_range(0, 3));
      waitIdle(100);
      repeat (16) @(posedge clk);
    end

    $display("[TB] random mid-conversion changes");
    for (int i = 0; i < 4; i++) begin
      applyStimulus($urandom_range(0, 255), $urandom_range(0, 3));
      repeat ($urandom_range(0, 7)) @(posedge clk);
      applyStimulus($urandom_range(0, 255), $urandom_range(0, 3));
      waitIdle(100);
      repeat (16) @(posedge clk);
    end

    $display("[TB] reset mid-shift with value 200");
    applyStimulus(200, 2);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("an_async_reset", an, 4'hF);
    checkOutput("seg_async_reset", seg, 8'hFF);
    checkOutput("busy_async_reset", busy, 0);
    releaseReset();
    waitIdle(100);
    repeat (20) @(posedge clk);

    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
